// File: rtl/cpu_top.sv
// cpu_top: 8-bit accumulator CPU with a 16-bit address space and a multi-cycle fetch/execute sequencer.
// Optional feature: define MULDIV_EN to implement MUL/DIV; otherwise opcodes 12/13 execute as NOP.
module cpu_top (
    input  logic        clk,
    input  logic        reset,
    inout  wire  [7:0]  data_bus,
    output logic [15:0] addr_bus,
    output logic        mem_read,
    output logic        mem_write,
    output logic [7:0]  acc_out,
    output logic [7:0]  x_out,
    output logic [7:0]  y_out,
    output logic [15:0] pc_out,
    output logic [7:0]  flags_out,
    output logic        halt
);
    localparam logic [7:0] OP_LDA_I = 8'h01, OP_LDA_D = 8'h02, OP_STA_D = 8'h03;
    localparam logic [7:0] OP_LDX_I = 8'h04, OP_LDY_I = 8'h05;
    localparam logic [7:0] OP_ADD_I = 8'h10, OP_SUB_I = 8'h11;
    localparam logic [7:0] OP_AND_I = 8'h20, OP_OR_I = 8'h21, OP_XOR_I = 8'h22, OP_NOT = 8'h23;
    localparam logic [7:0] OP_INC = 8'h30, OP_DEC = 8'h31, OP_SHL = 8'h32, OP_SHR = 8'h33;
    localparam logic [7:0] OP_ROL = 8'h34, OP_ROR = 8'h35;
    localparam logic [7:0] OP_BEQ = 8'h40, OP_BNE = 8'h41, OP_BRA = 8'h42, OP_HLT = 8'hFF;
`ifdef MULDIV_EN
    localparam logic [7:0] OP_MUL = 8'h12, OP_DIV = 8'h13;
`endif

    typedef enum logic [2:0] {
        S_FETCH, S_OPER, S_ADLO, S_ADHI, S_MEM, S_EXEC, S_HALT
    } state_t;

    state_t      state, state_n;
    logic [15:0] pc, pc_inc, br_target;
    logic [7:0]  acc, x, y, ir, adr_lo, adr_hi;
    logic        flag_c, flag_z, flag_n, flag_v;
    logic [7:0]  alu_res, alu_y;
    logic        alu_c, alu_v, alu_wr, br_taken;
    logic [8:0]  sum9, diff9;
`ifdef MULDIV_EN
    logic [15:0] product;
`endif

    // Bus strobes: a read is answered combinationally within the cycle mem_read is high;
    // a write commits ACC at the rising edge that ends the cycle mem_write is high.
    assign data_bus  = mem_write ? acc : 8'hzz;
    assign acc_out   = acc;
    assign x_out     = x;
    assign y_out     = y;
    assign pc_out    = pc;
    assign flags_out = {4'b0000, flag_v, flag_n, flag_z, flag_c};
    assign halt      = (state == S_HALT) && !reset;

    assign pc_inc    = pc + 16'd1;
    assign br_target = pc_inc + {{8{data_bus[7]}}, data_bus};
    assign br_taken  = (ir == OP_BRA) || (ir == OP_BEQ && flag_z) || (ir == OP_BNE && !flag_z);

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        addr_bus  = 16'h0000;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    addr_bus = pc;
                    mem_read = 1'b1;
                    case (data_bus)
                        OP_HLT: state_n = S_HALT;
                        OP_LDA_I, OP_LDX_I, OP_LDY_I, OP_ADD_I, OP_SUB_I,
                        OP_AND_I, OP_OR_I, OP_XOR_I, OP_BEQ, OP_BNE, OP_BRA: state_n = S_OPER;
                        OP_LDA_D, OP_STA_D: state_n = S_ADLO;
                        default: state_n = S_EXEC;
                    endcase
                end
                S_OPER, S_ADLO, S_ADHI: begin
                    addr_bus = pc;
                    mem_read = 1'b1;
                    state_n  = (state == S_OPER) ? S_FETCH : (state == S_ADLO) ? S_ADHI : S_MEM;
                end
                S_MEM: begin
                    addr_bus  = {adr_hi, adr_lo};
                    mem_write = (ir == OP_STA_D);
                    mem_read  = (ir != OP_STA_D);
                    state_n   = S_FETCH;
                end
                S_EXEC: begin
                    addr_bus = pc;
                    state_n  = S_FETCH;
                end
                S_HALT:  addr_bus = pc;
                default: state_n = S_FETCH;
            endcase
        end
    end

    // Operand for immediate ops is the byte on the bus during OPER.
    always_comb begin
        alu_res = acc;
        alu_y   = y;
        alu_c   = flag_c;
        alu_v   = flag_v;
        alu_wr  = 1'b0;
        sum9    = {1'b0, acc} + {1'b0, data_bus};
        diff9   = {1'b0, acc} - {1'b0, data_bus};
`ifdef MULDIV_EN
        product = {8'h00, acc} * {8'h00, x};
`endif
        case (ir)
            OP_LDA_I: begin alu_res = data_bus; alu_wr = 1'b1; end
            OP_ADD_I: begin
                alu_res = sum9[7:0];
                alu_c   = sum9[8];
                alu_v   = (acc[7] == data_bus[7]) && (sum9[7] != acc[7]);
                alu_wr  = 1'b1;
            end
            OP_SUB_I: begin
                alu_res = diff9[7:0];
                alu_c   = diff9[8];
                alu_v   = (acc[7] != data_bus[7]) && (diff9[7] != acc[7]);
                alu_wr  = 1'b1;
            end
            OP_AND_I: begin alu_res = acc & data_bus; alu_wr = 1'b1; end
            OP_OR_I:  begin alu_res = acc | data_bus; alu_wr = 1'b1; end
            OP_XOR_I: begin alu_res = acc ^ data_bus; alu_wr = 1'b1; end
            OP_NOT:   begin alu_res = ~acc;           alu_wr = 1'b1; end
            OP_INC:   begin alu_res = acc + 8'd1;     alu_wr = 1'b1; end
            OP_DEC:   begin alu_res = acc - 8'd1;     alu_wr = 1'b1; end
            OP_SHL:   begin {alu_c, alu_res} = {acc, 1'b0}; alu_wr = 1'b1; end
            OP_SHR:   begin {alu_res, alu_c} = {1'b0, acc}; alu_wr = 1'b1; end
            OP_ROL:   begin alu_res = {acc[6:0], acc[7]}; alu_c = acc[7]; alu_wr = 1'b1; end
            OP_ROR:   begin alu_res = {acc[0], acc[7:1]}; alu_c = acc[0]; alu_wr = 1'b1; end
`ifdef MULDIV_EN
            OP_MUL:   begin {alu_y, alu_res} = product; alu_wr = 1'b1; end
            OP_DIV: begin
                alu_wr = 1'b1;
                if (x != 8'h00) begin
                    alu_res = acc / x;
                    alu_y   = acc % x;
                    alu_v   = 1'b0;
                end else begin
                    alu_res = 8'hFF;
                    alu_y   = acc;
                    alu_v   = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= 16'h0000;
            acc    <= 8'h00;
            x      <= 8'h00;
            y      <= 8'h00;
            ir     <= 8'h00;
            adr_lo <= 8'h00;
            adr_hi <= 8'h00;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_v <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin ir <= data_bus; pc <= pc_inc; end
                S_OPER: begin
                    pc <= br_taken ? br_target : pc_inc;
                    if (ir == OP_LDX_I) x <= data_bus;
                    if (ir == OP_LDY_I) y <= data_bus;
                end
                S_ADLO: begin adr_lo <= data_bus; pc <= pc_inc; end
                S_ADHI: begin adr_hi <= data_bus; pc <= pc_inc; end
                S_MEM: begin
                    if (ir == OP_LDA_D) begin
                        acc    <= data_bus;
                        flag_z <= (data_bus == 8'h00);
                        flag_n <= data_bus[7];
                    end
                end
                default: ;
            endcase
            if (state == S_OPER || state == S_EXEC) begin
                if (alu_wr) begin
                    acc    <= alu_res;
                    flag_z <= (alu_res == 8'h00);
                    flag_n <= alu_res[7];
                end
                y      <= (ir == OP_LDY_I) ? data_bus : alu_y;
                flag_c <= alu_c;
                flag_v <= alu_v;
            end
        end
    end
endmodule

// File: tb/tb_cpu_top.sv
// Testbench for cpu_top: directed programs plus random memory images, checked
// instruction by instruction against an ISA-level reference model.
module tb_cpu_top;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  wire  [7:0]  data_bus;
  logic [15:0] addr_bus, pc_out;
  logic        mem_read, mem_write, halt;
  logic [7:0]  acc_out, x_out, y_out, flags_out;

  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [7:0]  prog[$];
  logic [23:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_writes = 0;

  int m_pc, m_acc, m_x, m_y;
  bit m_c, m_z, m_n, m_v, m_halt;

  logic [7:0] ops [0:22] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h10, 8'h11, 8'h12,
                             8'h13, 8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'h31, 8'h32, 8'h33,
                             8'h34, 8'h35, 8'h40, 8'h41, 8'h42};

  cpu_top dut (
    .clk(clk), .reset(reset), .data_bus(data_bus), .addr_bus(addr_bus),
    .mem_read(mem_read), .mem_write(mem_write), .acc_out(acc_out), .x_out(x_out),
    .y_out(y_out), .pc_out(pc_out), .flags_out(flags_out), .halt(halt)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // memory model
  assign data_bus = mem_read ? mem[addr_bus] : 8'hzz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // write scoreboard: each DUT write must match the next expected {addr, data}
  always @(negedge clk) begin
    if (mem_read && mem_write) check("rd_wr_exclusive", 1, 0);
    if (mem_write) begin
      n_writes++;
      mem[addr_bus] = data_bus;
      if (exp_q.size() == 0) check("unexpected_write", {addr_bus, data_bus}, 24'h0);
      else check("write", {addr_bus, data_bus}, exp_q.pop_front());
    end
  end

  // reference model
  function automatic int sx(input int b);
    return (b > 127) ? b - 256 : b;
  endfunction

  task automatic set_nz();
    m_z = (m_acc == 0);
    m_n = (m_acc >= 128);
  endtask

  task automatic model_reset();
    m_pc = 0; m_acc = 0; m_x = 0; m_y = 0;
    m_c = 0; m_z = 0; m_n = 0; m_v = 0; m_halt = 0;
  endtask

  task automatic model_step(output int cyc);
    int op, b1, b2, a, t, s, p;
    bit taken;
    cyc = 2;
    if (m_halt) begin cyc = 1; return; end
    op = ref_mem[m_pc];
    b1 = ref_mem[(m_pc + 1) & 'hFFFF];
    b2 = ref_mem[(m_pc + 2) & 'hFFFF];
    case (op)
      'h01: begin m_acc = b1; set_nz(); m_pc += 2; end
      'h02: begin a = b2 * 256 + b1; m_acc = ref_mem[a]; set_nz(); m_pc += 3; cyc = 4; end
      'h03: begin
        a = b2 * 256 + b1;
        ref_mem[a] = m_acc[7:0];
        exp_q.push_back({a[15:0], m_acc[7:0]});
        m_pc += 3; cyc = 4;
      end
      'h04: begin m_x = b1; m_pc += 2; end
      'h05: begin m_y = b1; m_pc += 2; end
      'h10: begin
        t = m_acc + b1; m_c = (t > 255);
        s = sx(m_acc) + sx(b1); m_v = (s > 127) || (s < -128);
        m_acc = t % 256; set_nz(); m_pc += 2;
      end
      'h11: begin
        m_c = (b1 > m_acc);
        s = sx(m_acc) - sx(b1); m_v = (s > 127) || (s < -128);
        m_acc = (m_acc - b1 + 256) % 256; set_nz(); m_pc += 2;
      end
`ifdef MULDIV_EN
      'h12: begin p = m_acc * m_x; m_y = p / 256; m_acc = p % 256; set_nz(); m_pc += 1; end
      'h13: begin
        if (m_x != 0) begin m_y = m_acc % m_x; m_acc = m_acc / m_x; m_v = 0; end
        else begin m_y = m_acc; m_acc = 255; m_v = 1; end
        set_nz(); m_pc += 1;
      end
`endif
      'h20: begin m_acc = m_acc & b1; set_nz(); m_pc += 2; end
      'h21: begin m_acc = m_acc | b1; set_nz(); m_pc += 2; end
      'h22: begin m_acc = m_acc ^ b1; set_nz(); m_pc += 2; end
      'h23: begin m_acc = 255 - m_acc; set_nz(); m_pc += 1; end
      'h30: begin m_acc = (m_acc + 1) % 256; set_nz(); m_pc += 1; end
      'h31: begin m_acc = (m_acc + 255) % 256; set_nz(); m_pc += 1; end
      'h32: begin m_c = (m_acc >= 128); m_acc = (m_acc * 2) % 256; set_nz(); m_pc += 1; end
      'h33: begin m_c = (m_acc % 2 == 1); m_acc = m_acc / 2; set_nz(); m_pc += 1; end
      'h34: begin m_c = (m_acc >= 128); m_acc = (m_acc * 2) % 256 + (m_c ? 1 : 0); set_nz(); m_pc += 1; end
      'h35: begin m_c = (m_acc % 2 == 1); m_acc = m_acc / 2 + (m_c ? 128 : 0); set_nz(); m_pc += 1; end
      'h40, 'h41, 'h42: begin
        taken = (op == 'h42) || (op == 'h40 && m_z) || (op == 'h41 && !m_z);
        m_pc = m_pc + 2 + (taken ? sx(b1) : 0);
      end
      'hFF: begin m_halt = 1; m_pc += 1; cyc = 1; end
      default: m_pc += 1;
    endcase
    m_pc = m_pc & 'hFFFF;
  endtask

  task automatic compare_state(input string tag);
    check({tag, "_pc"}, pc_out, m_pc);
    check({tag, "_acc"}, acc_out, m_acc);
    check({tag, "_x"}, x_out, m_x);
    check({tag, "_y"}, y_out, m_y);
    check({tag, "_flags"}, flags_out, {4'b0000, m_v, m_n, m_z, m_c});
    check({tag, "_halt"}, halt, m_halt);
  endtask

  // driver tasks
  task automatic run_instr(input string tag);
    int cyc;
    check({tag, "_addr"}, addr_bus, m_pc);
    check({tag, "_rd"}, mem_read, !m_halt);
    model_step(cyc);
    repeat (cyc) @(negedge clk);
    #1;
    compare_state(tag);
  endtask

  task automatic reset_release();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    compare_state("rst");
  endtask

  task automatic do_reset();
    check("q_empty_before_reset", exp_q.size(), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_rd", mem_read, 0);
    check("rst_wr", mem_write, 0);
    check("rst_addr", addr_bus, 0);
    check("rst_halt", halt, 0);
    reset_release();
  endtask

  task automatic load_prog();
    for (int i = 0; i < 65536; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    for (int i = 0; i < prog.size(); i++) begin mem[i] = prog[i]; ref_mem[i] = prog[i]; end
  endtask

  initial begin
    logic [7:0] main_acc [0:7] = '{8'h55, 8'h55, 8'h5F, 8'h5A, 8'h5A, 8'h5F, 8'hA0, 8'hA0};
    int wr_before;
    model_reset();

    // main program
    prog = '{8'h01, 8'h55, 8'h04, 8'hAA, 8'h10, 8'h0A, 8'h11, 8'h05,
             8'h20, 8'hFF, 8'h21, 8'h0F, 8'h23, 8'h00};
    load_prog();
    do_reset();
    check("first_fetch_addr", addr_bus, 16'h0000);
    check("first_fetch_rd", mem_read, 1);
    for (int i = 0; i < 8; i++) begin
      run_instr("main");
      check("main_acc_seq", acc_out, main_acc[i]);
    end
    check("main_x", x_out, 8'hAA);
    check("main_flags", flags_out, 8'h04);
    check("main_pc", pc_out, 16'h000E);

    // carry / overflow / borrow
    prog = '{8'h01, 8'hFF, 8'h10, 8'h01, 8'h01, 8'h7F, 8'h10, 8'h01, 8'h01, 8'h00, 8'h11, 8'h01};
    load_prog();
    do_reset();
    run_instr("cv"); run_instr("cv");
    check("carry_acc", acc_out, 8'h00); check("carry_flags", flags_out, 8'h03);
    run_instr("cv"); run_instr("cv");
    check("ovf_acc", acc_out, 8'h80); check("ovf_flags", flags_out, 8'h0C);
    run_instr("cv"); run_instr("cv");
    check("borrow_acc", acc_out, 8'hFF); check("borrow_flags", flags_out, 8'h05);

    // direct store / load
    prog = '{8'h01, 8'h3C, 8'h03, 8'h00, 8'h02, 8'h01, 8'h00, 8'h02, 8'h00, 8'h02};
    load_prog();
    do_reset();
    wr_before = n_writes;
    for (int i = 0; i < 4; i++) run_instr("dir");
    check("dir_write_count", n_writes - wr_before, 1);
    check("dir_mem", mem[16'h0200], 8'h3C);
    check("dir_acc", acc_out, 8'h3C);

    // branches
    prog = '{8'h01, 8'h00, 8'h40, 8'h02, 8'hFF, 8'hFF, 8'h41, 8'h05, 8'h42, 8'hFE};
    load_prog();
    do_reset();
    run_instr("br"); run_instr("br");
    check("beq_taken_pc", pc_out, 16'h0006);
    run_instr("br");
    check("bne_not_taken_pc", pc_out, 16'h0008);
    run_instr("br"); run_instr("br");
    check("bra_loop_pc", pc_out, 16'h0008);

    // MUL / DIV
    prog = '{8'h01, 8'h0C, 8'h04, 8'h0A, 8'h12, 8'h01, 8'h64, 8'h04, 8'h07, 8'h13,
             8'h04, 8'h00, 8'h13};
    load_prog();
    do_reset();
    for (int i = 0; i < 3; i++) run_instr("md");
`ifdef MULDIV_EN
    check("mul_acc", acc_out, 8'h78); check("mul_y", y_out, 8'h00);
`else
    check("mul_off_acc", acc_out, 8'h0C); check("mul_off_y", y_out, 8'h00);
`endif
    for (int i = 0; i < 3; i++) run_instr("md");
`ifdef MULDIV_EN
    check("div_acc", acc_out, 8'h0E); check("div_y", y_out, 8'h02);
`else
    check("div_off_acc", acc_out, 8'h64); check("div_off_y", y_out, 8'h00);
`endif
    run_instr("md"); run_instr("md");
`ifdef MULDIV_EN
    check("div0_acc", acc_out, 8'hFF); check("div0_flags", flags_out, 8'h0C);
    check("div0_y", y_out, 8'h0E);
`else
    check("div0_off_acc", acc_out, 8'h64); check("div0_off_flags", flags_out, 8'h00);
`endif

    // HLT then reset from halt
    prog = '{8'h01, 8'h11, 8'hFF, 8'h01, 8'h22};
    load_prog();
    do_reset();
    run_instr("hlt"); run_instr("hlt");
    check("hlt_halt", halt, 1);
    for (int i = 0; i < 4; i++) run_instr("halted");
    check("hlt_pc_frozen", pc_out, 16'h0003);
    check("hlt_wr", mem_write, 0);
    do_reset();
    check("hlt_reset_pc", pc_out, 16'h0000);
    run_instr("post_hlt");
    check("post_hlt_acc", acc_out, 8'h11);

    // reset arriving while the STA bus cycle is underway
    prog = '{8'h01, 8'h3C, 8'h03, 8'h00, 8'h03};
    load_prog();
    do_reset();
    run_instr("sta_rst");
    wr_before = n_writes;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("sta_rst_wr", mem_write, 0);
    check("sta_rst_rd", mem_read, 0);
    check("sta_rst_addr", addr_bus, 16'h0000);
    reset_release();
    check("sta_rst_no_write", n_writes - wr_before, 0);
    check("sta_rst_mem", mem[16'h0300], 8'h00);

    // random memory images
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 65536; i++) begin
        logic [7:0] b;
        b = $urandom_range(0, 1) ? ops[$urandom_range(0, 22)] : 8'($urandom_range(0, 255));
        mem[i] = b;
        ref_mem[i] = b;
      end
      do_reset();
      for (int k = 0; k < 150; k++) begin
        run_instr("rnd");
        if (m_halt) break;
      end
      run_instr("rnd_tail");
    end

    // final report
    check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
